// File: rtl/st_backend_ctrl_store.sv
// Store-side back-end controller: takes R-Config words, one attribute word and
// a payload from the link, and turns the payload into paced memory writes.
module st_backend_ctrl_store #(
   parameter int WIDTH_DATA = 32,
   parameter int WIDTH_LEN  = 16,
   parameter int NUM_RCFG   = 2,
   localparam int RCFG_W    = (NUM_RCFG > 1) ? $clog2(NUM_RCFG) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  I_Event_Store,
   input  logic                  is_Bypass,
   input  logic                  I_Valid,
   input  logic [WIDTH_DATA-1:0] I_Data,
   input  logic                  I_Stall,
   input  logic                  I_Term_AddrGen,
   output logic                  O_Nack,
   output logic                  O_Sleep,
   output logic                  O_Run,
   output logic                  O_Set_RConfig,
   output logic                  O_Load_RConfig,
   output logic [RCFG_W-1:0]     O_RCfg_Idx,
   output logic                  O_Set_AttribWord,
   output logic [WIDTH_LEN-1:0]  O_Length,
   output logic                  O_We,
   output logic [WIDTH_DATA-1:0] O_Wr_Data,
   output logic [WIDTH_LEN-1:0]  O_Count,
   output logic                  O_Tail_Store,
   output logic                  O_End_Store
);

   typedef enum logic [2:0] {
      ST_INIT       = 3'd0,
      ST_GET_RCFG   = 3'd1,
      ST_GET_ATTRIB = 3'd2,
      ST_STORE      = 3'd3,
      ST_TAIL       = 3'd4,
      ST_END        = 3'd5
   } state_t;

   localparam logic [WIDTH_LEN-1:0] LEN_ONE  = WIDTH_LEN'(1);
   localparam logic [RCFG_W-1:0]    IDX_ONE  = RCFG_W'(1);
   localparam logic [RCFG_W-1:0]    IDX_LAST = RCFG_W'(NUM_RCFG - 1);

   state_t                 state;
   state_t                 state_next;
   logic [WIDTH_LEN-1:0]   r_cnt;
   logic [RCFG_W-1:0]      r_rcfg_idx;
   logic [WIDTH_LEN-1:0]   r_length;
   logic                   nack;
   logic                   accept;
   logic                   last_beat;
   logic [WIDTH_LEN-1:0]   attrib_len;

   assign accept     = I_Valid & ~nack;
   assign last_beat  = accept && (r_cnt == r_length - LEN_ONE);
   assign attrib_len = I_Data[WIDTH_LEN-1:0];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_INIT;
      end else begin
         state <= state_next;
      end
   end

   // Counters and captured length; INIT clears per-block progress.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_rcfg_idx <= '0;
         r_length   <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               r_cnt      <= '0;
               r_rcfg_idx <= '0;
            end
            ST_GET_RCFG: begin
               if (accept) r_rcfg_idx <= r_rcfg_idx + IDX_ONE;
            end
            ST_GET_ATTRIB: begin
               if (accept) r_length <= attrib_len;
            end
            ST_STORE, ST_TAIL: begin
               if (accept) r_cnt <= r_cnt + LEN_ONE;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_INIT: begin
            if (I_Event_Store) state_next = is_Bypass ? ST_GET_ATTRIB : ST_GET_RCFG;
         end
         ST_GET_RCFG: begin
            if (accept && (r_rcfg_idx == IDX_LAST)) state_next = ST_GET_ATTRIB;
         end
         ST_GET_ATTRIB: begin
            if (accept) state_next = (attrib_len == '0) ? ST_END : ST_STORE;
         end
         ST_STORE: begin
            // Completion takes priority over address-generator exhaustion.
            if (last_beat)           state_next = ST_END;
            else if (I_Term_AddrGen) state_next = ST_TAIL;
         end
         ST_TAIL: begin
            if ((r_cnt >= r_length) || last_beat) state_next = ST_END;
         end
         ST_END:  state_next = ST_INIT;
         default: state_next = ST_INIT;
      endcase
   end

   always_comb begin
      nack = 1'b1;
      case (state)
         ST_GET_RCFG, ST_GET_ATTRIB, ST_TAIL: nack = 1'b0;
         ST_STORE:                            nack = I_Stall;
         default:                             nack = 1'b1;
      endcase
   end

   always_comb begin
      O_Nack           = nack;
      O_Sleep          = (state == ST_INIT);
      O_Run            = (state == ST_STORE) || (state == ST_TAIL) || (state == ST_END);
      O_Set_RConfig    = (state == ST_GET_RCFG);
      O_Load_RConfig   = (state == ST_GET_RCFG) && accept;
      O_RCfg_Idx       = r_rcfg_idx;
      O_Set_AttribWord = (state == ST_GET_ATTRIB) && accept;
      O_Length         = r_length;
      O_We             = (state == ST_STORE) && accept;
      O_Wr_Data        = I_Data;
      O_Count          = r_cnt;
      O_Tail_Store     = (state == ST_TAIL);
      O_End_Store      = (state == ST_END);
   end

endmodule
